// File: rtl/store_packer.sv
// Narrows 32-bit store data to lane-replicated words with byte enables and queues them in a DEPTH-entry FIFO.
// One cycle from accept to mem_valid; req_ready drops while the FIFO is full, with no pass-through.
module store_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [31:0]            req_data,
  input  logic [1:0]             req_size,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic                   err_pulse,
  output logic [AW-1:0]          err_addr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [AW-1:0] addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic        full, empty, accept, push, pop, illegal;
  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;

  always_comb begin
    pk_wdata = '0;
    pk_be    = '0;
    illegal  = 1'b0;
    case (req_size)
      2'b00: begin
        pk_wdata = {4{req_data[7:0]}};
        pk_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        pk_wdata = {2{req_data[15:0]}};
        pk_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        illegal  = req_addr[0];
      end
      2'b10: begin
        pk_wdata = req_data;
        pk_be    = 4'b1111;
        illegal  = |req_addr[1:0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign req_ready = ~full & ~rst;
  assign accept    = req_valid & req_ready;
  // Rejected requests complete the handshake but never occupy a slot.
  assign push      = accept & ~illegal;
  assign mem_valid = ~empty;
  assign pop       = mem_valid & mem_ready;

  assign mem_addr  = empty ? '0 : addr_q[rd_ptr];
  assign mem_wdata = empty ? '0 : wdata_q[rd_ptr];
  assign mem_be    = empty ? '0 : be_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_pulse <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr]  <= {req_addr[AW-1:2], 2'b00};
        wdata_q[wr_ptr] <= pk_wdata;
        be_q[wr_ptr]    <= pk_be;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      err_pulse <= accept & illegal;
      if (accept & illegal) err_addr <= req_addr;
    end
  end

endmodule
